// File: rtl/ks_sub_pipe.sv
// ks_sub_pipe
//   Three-stage pipelined Kogge-Stone subtractor: d = a - b - bin (mod 2^WIDTH).
//   Computed as a + ~b + cin with cin = ~bin; the prefix tree is split across
//   stages 2 and 3. All stages advance together under a valid/ready handshake.
//
//   Optional build macro: KS_SUB_ABS_EN
//     When defined, stage 3 returns the magnitude |a - b - bin| (two's-complement
//     negation through a second Kogge-Stone increment), and o_borrow acts as the
//     sign. When undefined, o_d is the raw two's-complement difference.
//
// Ports
//   i_clk     clock, rising edge
//   i_rst     asynchronous active-high reset
//   i_valid   input operands valid
//   o_ready   pipe can accept an operand this cycle (~o_valid | i_ready)
//   i_a       minuend, WIDTH bits
//   i_b       subtrahend, WIDTH bits
//   i_bin     borrow in
//   o_valid   result valid
//   i_ready   downstream accepts the result
//   o_d       difference (or magnitude with KS_SUB_ABS_EN), WIDTH bits
//   o_borrow  1 when a < b + bin (unsigned)
//   o_zero    1 when o_d == 0
module ks_sub_pipe #(
    parameter int WIDTH = 24
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_d,
    output logic             o_borrow,
    output logic             o_zero
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int SPLIT  = (LEVELS + 1) / 2;

    logic             adv;
    logic             v1, v2, v3;

    logic [WIDTH-1:0] in_g, in_p;
    logic [WIDTH-1:0] s1_g, s1_p;
    logic             s1_cin;

    logic [WIDTH-1:0] mid_g, mid_p, mid_tg, mid_tp;
    logic [WIDTH-1:0] s2_g, s2_p, s2_x;
    logic             s2_cin;

    logic [WIDTH-1:0] fin_g, fin_p, fin_tg, fin_tp;
    logic [WIDTH-1:0] carries, raw;
    logic             res_borrow;
    logic [WIDTH-1:0] res_d;

    // A single advance signal keeps every stage in lock-step; a full output
    // stage that is not being drained freezes the whole pipe.
    assign adv     = ~v3 | i_ready;
    assign o_ready = adv;
    assign o_valid = v3;

    // Bit-level generate/propagate of a + ~b; the carry-in is folded into the
    // bit-0 generate so the prefix tree yields carries directly.
    assign in_p = i_a ^ ~i_b;
    assign in_g = (i_a & ~i_b) | {{(WIDTH-1){1'b0}}, in_p[0] & ~i_bin};

    // First half of the prefix levels (distances 1 .. 2^(SPLIT-1)).
    always_comb begin
        mid_g  = s1_g;
        mid_p  = s1_p;
        mid_tg = s1_g;
        mid_tp = s1_p;
        for (int k = 0; k < SPLIT; k++) begin
            mid_tg = mid_g;
            mid_tp = mid_p;
            for (int i = (1 << k); i < WIDTH; i++) begin
                mid_g[i] = mid_tg[i] | (mid_tp[i] & mid_tg[i - (1 << k)]);
                mid_p[i] = mid_tp[i] & mid_tp[i - (1 << k)];
            end
        end
    end

    // Remaining prefix levels, then the sum XOR with the original propagate.
    // fin_g[i] is the carry out of bit i, including the carry-in.
    always_comb begin
        fin_g  = s2_g;
        fin_p  = s2_p;
        fin_tg = s2_g;
        fin_tp = s2_p;
        for (int k = SPLIT; k < LEVELS; k++) begin
            fin_tg = fin_g;
            fin_tp = fin_p;
            for (int i = (1 << k); i < WIDTH; i++) begin
                fin_g[i] = fin_tg[i] | (fin_tp[i] & fin_tg[i - (1 << k)]);
                fin_p[i] = fin_tp[i] & fin_tp[i - (1 << k)];
            end
        end
    end

    assign carries    = {fin_g[WIDTH-2:0], s2_cin};
    assign raw        = s2_x ^ carries;
    assign res_borrow = ~fin_g[WIDTH-1];

`ifdef KS_SUB_ABS_EN
    logic [WIDTH-1:0] inv, all_ones, all_tmp, inc_carry, mag;

    // -raw = ~raw + 1: the carry into bit i is the AND of all lower bits of
    // ~raw, built with the same log-depth prefix structure.
    assign inv = ~raw;

    always_comb begin
        all_ones = inv;
        all_tmp  = inv;
        for (int k = 0; k < LEVELS; k++) begin
            all_tmp = all_ones;
            for (int i = (1 << k); i < WIDTH; i++) begin
                all_ones[i] = all_tmp[i] & all_tmp[i - (1 << k)];
            end
        end
    end

    assign inc_carry = {all_ones[WIDTH-2:0], 1'b1};
    assign mag       = inv ^ inc_carry;
    assign res_d     = res_borrow ? mag : raw;
`else
    assign res_d     = raw;
`endif

    // Pipeline registers. Data registers of empty stages load freely; only
    // the valid bits give them meaning.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            s1_g     <= '0;
            s1_p     <= '0;
            s1_cin   <= 1'b0;
            s2_g     <= '0;
            s2_p     <= '0;
            s2_x     <= '0;
            s2_cin   <= 1'b0;
            o_d      <= '0;
            o_borrow <= 1'b0;
            o_zero   <= 1'b0;
        end else if (adv) begin
            v1       <= i_valid;
            v2       <= v1;
            v3       <= v2;
            s1_g     <= in_g;
            s1_p     <= in_p;
            s1_cin   <= ~i_bin;
            s2_g     <= mid_g;
            s2_p     <= mid_p;
            s2_x     <= s1_p;
            s2_cin   <= s1_cin;
            o_d      <= res_d;
            o_borrow <= res_borrow;
            o_zero   <= (res_d == '0);
        end
    end

endmodule
